// File: rtl/onehot_select_arbiter.sv
// ============================================================================
// Module      : onehot_select_arbiter
// Description : Four-requester round-robin arbiter producing the registered
//               one-hot select for a downstream 4:1 output mux
//               (select[0]->a, select[1]->b, select[2]->c, select[3]->d).
//               A grant is held until the owner pulses done, drops its
//               request, or exceeds HOLD_MAX cycles while another requester
//               waits. Every grant is followed by one all-zero select cycle
//               (break-before-make).
// Revision    : 1.0 - initial release
// ----------------------------------------------------------------------------
// Ports
//   clk          in   1  single clock, all state on rising edge
//   rst_n        in   1  asynchronous active-low reset
//   req          in   4  level requests, bit i = mux input i
//   done         in   1  one-cycle release pulse from the current owner
//   select       out  4  registered one-hot select, 4'b0000 when idle
//   grant_valid  out  1  high while select is non-zero
//   grant_id     out  2  binary index of the set select bit, 0 when idle
//   timeout      out  1  one-cycle pulse when a grant is revoked by HOLD_MAX
// Parameters
//   HOLD_MAX     max grant cycles while another request is pending (0 = no limit)
//   CNT_W        hold counter width, HOLD_MAX < 2**CNT_W
// ============================================================================
`default_nettype none

module onehot_select_arbiter #(
    parameter int HOLD_MAX = 16,
    parameter int CNT_W    = 8
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [3:0] req,
    input  logic       done,
    output logic [3:0] select,
    output logic       grant_valid,
    output logic [1:0] grant_id,
    output logic       timeout
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_GRANT = 2'd1,
        ST_GAP   = 2'd2
    } state_t;

    localparam logic [CNT_W-1:0] c_CNT_MAX   = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0] c_CNT_ONE   = {{(CNT_W-1){1'b0}}, 1'b1};
    // Counter value seen on the last allowed grant cycle. The counter is 0
    // on the first grant cycle, so HOLD_MAX-1 marks cycle number HOLD_MAX.
    localparam logic [CNT_W-1:0] c_HOLD_LAST =
        (HOLD_MAX == 0) ? {CNT_W{1'b0}} : CNT_W'(HOLD_MAX - 1);
    localparam bit               c_HOLD_ON   = (HOLD_MAX != 0);

    // ------------------------------------------------------------------
    // Registered state
    // ------------------------------------------------------------------
    state_t           r_state;
    logic [1:0]       r_ptr;
    logic [CNT_W-1:0] r_cnt;
    logic [3:0]       r_select;
    logic             r_grant_valid;
    logic [1:0]       r_grant_id;
    logic             r_timeout;

    // ------------------------------------------------------------------
    // Next-state signals
    // ------------------------------------------------------------------
    state_t           w_state_nxt;
    logic [1:0]       w_ptr_nxt;
    logic [CNT_W-1:0] w_cnt_nxt;
    logic [3:0]       w_select_nxt;
    logic             w_timeout_nxt;

    logic [1:0]       w_winner;
    logic             w_any_req;
    logic             w_others_waiting;
    logic             w_release;
    logic             w_hold_expired;

    // First set request bit scanning ptr, ptr+1, ... modulo 4.
    function automatic logic [1:0] rr_pick(input logic [3:0] r, input logic [1:0] p);
        logic [1:0] idx;
        logic [1:0] win;
        logic       found;
        win   = 2'd0;
        found = 1'b0;
        for (int k = 0; k < 4; k++) begin
            idx = p + k[1:0];
            if (!found && r[idx]) begin
                win   = idx;
                found = 1'b1;
            end
        end
        return win;
    endfunction

    function automatic logic [3:0] to_onehot(input logic [1:0] idx);
        return 4'b0001 << idx;
    endfunction

    function automatic logic [1:0] encode(input logic [3:0] oh);
        logic [1:0] idx;
        case (oh)
            4'b0010: idx = 2'd1;
            4'b0100: idx = 2'd2;
            4'b1000: idx = 2'd3;
            default: idx = 2'd0;
        endcase
        return idx;
    endfunction

    assign w_winner         = rr_pick(req, r_ptr);
    assign w_any_req        = |req;
    assign w_others_waiting = |(req & ~r_select);
    assign w_release        = done || !req[r_grant_id];
    // A timeout only counts when something else is actually waiting; a lone
    // requester may keep the mux indefinitely.
    assign w_hold_expired   = c_HOLD_ON && (r_cnt == c_HOLD_LAST) && w_others_waiting;

    // ------------------------------------------------------------------
    // Next-state and output logic
    // ------------------------------------------------------------------
    always_comb begin
        w_state_nxt   = r_state;
        w_ptr_nxt     = r_ptr;
        w_cnt_nxt     = r_cnt;
        w_select_nxt  = r_select;
        w_timeout_nxt = 1'b0;

        case (r_state)
            // GAP arbitrates exactly like IDLE; its only purpose is the
            // forced zero cycle already produced when leaving GRANT.
            ST_IDLE, ST_GAP: begin
                if (w_any_req) begin
                    w_state_nxt  = ST_GRANT;
                    w_select_nxt = to_onehot(w_winner);
                    w_cnt_nxt    = {CNT_W{1'b0}};
                end else begin
                    w_state_nxt  = ST_IDLE;
                    w_select_nxt = 4'b0000;
                end
            end

            ST_GRANT: begin
                if (w_release || w_hold_expired) begin
                    w_state_nxt   = ST_GAP;
                    w_select_nxt  = 4'b0000;
                    w_ptr_nxt     = r_grant_id + 2'd1;
                    // A voluntary release wins over a coincident timeout.
                    w_timeout_nxt = w_hold_expired && !w_release;
                end else if (r_cnt != c_CNT_MAX) begin
                    w_cnt_nxt = r_cnt + c_CNT_ONE;
                end
            end

            default: begin
                w_state_nxt  = ST_IDLE;
                w_select_nxt = 4'b0000;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state       <= ST_IDLE;
            r_ptr         <= 2'd0;
            r_cnt         <= {CNT_W{1'b0}};
            r_select      <= 4'b0000;
            r_grant_valid <= 1'b0;
            r_grant_id    <= 2'd0;
            r_timeout     <= 1'b0;
        end else begin
            r_state       <= w_state_nxt;
            r_ptr         <= w_ptr_nxt;
            r_cnt         <= w_cnt_nxt;
            r_select      <= w_select_nxt;
            // Derived from the same next value so they never disagree
            // with select.
            r_grant_valid <= |w_select_nxt;
            r_grant_id    <= encode(w_select_nxt);
            r_timeout     <= w_timeout_nxt;
        end
    end

    assign select      = r_select;
    assign grant_valid = r_grant_valid;
    assign grant_id    = r_grant_id;
    assign timeout     = r_timeout;

endmodule

`default_nettype wire

// File: tb/tb_onehot_select_arbiter.sv
// ============================================================================
// Module      : tb_onehot_select_arbiter
// Description : Directed self-checking bench for onehot_select_arbiter.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_onehot_select_arbiter;

    logic       clk;
    logic       rst_n;
    logic [3:0] req;
    logic       done;
    logic [3:0] select;
    logic       grant_valid;
    logic [1:0] grant_id;
    logic       timeout;

    int checks;
    int errors;

    onehot_select_arbiter #(
        .HOLD_MAX (16),
        .CNT_W    (8)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .req         (req),
        .done        (done),
        .select      (select),
        .grant_valid (grant_valid),
        .grant_id    (grant_id),
        .timeout     (timeout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Structural invariants sampled every falling edge.
    always @(negedge clk) begin
        logic [1:0] exp_id;
        case (select)
            4'b0010: exp_id = 2'd1;
            4'b0100: exp_id = 2'd2;
            4'b1000: exp_id = 2'd3;
            default: exp_id = 2'd0;
        endcase
        checks++;
        if ($countones(select) > 1) begin
            errors++;
            $display("FAIL inv_onehot select=%b required one-hot or zero", select);
        end
        checks++;
        if (grant_valid !== (select != 4'b0000)) begin
            errors++;
            $display("FAIL inv_grant_valid got=%b required=%b (select=%b)", grant_valid, (select != 4'b0000), select);
        end
        checks++;
        if (grant_id !== exp_id) begin
            errors++;
            $display("FAIL inv_grant_id got=%0d required=%0d (select=%b)", grant_id, exp_id, select);
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic apply_reset(input logic [3:0] r);
        rst_n = 1'b0;
        req   = r;
        done  = 1'b0;
        step();
        step();
        rst_n = 1'b1;
    endtask

    // Pulse done for one edge, check the gap cycle, then the next owner.
    task automatic release_and_expect(input string name, input logic [3:0] nxt);
        done = 1'b1;
        step();
        done = 1'b0;
        checks++;
        if (select !== 4'b0000) begin
            errors++;
            $display("FAIL %s_gap select=%b required=0000", name, select);
        end
        step();
        checks++;
        if (select !== nxt) begin
            errors++;
            $display("FAIL %s_next select=%b required=%b", name, select, nxt);
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        req   = 4'b1111;
        done  = 1'b0;
        step();
        step();
        checks++;
        if ({select, grant_valid, grant_id, timeout} !== 8'b0) begin
            errors++;
            $display("FAIL reset_state sel=%b gv=%b id=%0d to=%b required all zero", select, grant_valid, grant_id, timeout);
        end
        rst_n = 1'b1;
        checks++;
        if (select !== 4'b0000) begin
            errors++;
            $display("FAIL reset_release_before_edge select=%b required=0000", select);
        end
        step();
        checks++;
        if (select !== 4'b0001) begin
            errors++;
            $display("FAIL reset_first_grant select=%b required=0001", select);
        end
        release_and_expect("reset_done", 4'b0010);
    endtask

    task automatic test_round_robin();
        logic [3:0] exp;
        apply_reset(4'b1111);
        step();
        exp = 4'b0001;
        checks++;
        if (select !== exp) begin
            errors++;
            $display("FAIL rr_first select=%b required=%b", select, exp);
        end
        for (int k = 0; k < 4; k++) begin
            step();
            checks++;
            if (select !== exp) begin
                errors++;
                $display("FAIL rr_hold%0d select=%b required=%b", k, select, exp);
            end
            exp = {exp[2:0], exp[3]};
            release_and_expect("rr", exp);
        end
    endtask

    task automatic test_timeout();
        apply_reset(4'b0101);
        step();
        for (int i = 1; i <= 16; i++) begin
            checks++;
            if (select !== 4'b0001 || timeout !== 1'b0) begin
                errors++;
                $display("FAIL to_hold cycle=%0d select=%b timeout=%b required 0001/0", i, select, timeout);
            end
            step();
        end
        checks++;
        if (select !== 4'b0000 || timeout !== 1'b1) begin
            errors++;
            $display("FAIL to_gap select=%b timeout=%b required 0000/1", select, timeout);
        end
        step();
        checks++;
        if (select !== 4'b0100 || timeout !== 1'b0) begin
            errors++;
            $display("FAIL to_next select=%b timeout=%b required 0100/0", select, timeout);
        end
        step();
        checks++;
        if (select !== 4'b0100 || timeout !== 1'b0) begin
            errors++;
            $display("FAIL to_after select=%b timeout=%b required 0100/0", select, timeout);
        end
    endtask

    task automatic test_done_with_timeout();
        apply_reset(4'b0101);
        step();
        for (int i = 1; i < 16; i++) step();
        done = 1'b1;
        step();
        done = 1'b0;
        checks++;
        if (select !== 4'b0000 || timeout !== 1'b0) begin
            errors++;
            $display("FAIL done_to_gap select=%b timeout=%b required 0000/0", select, timeout);
        end
        step();
        checks++;
        if (select !== 4'b0100) begin
            errors++;
            $display("FAIL done_to_next select=%b required=0100", select);
        end
    endtask

    task automatic test_single_requester();
        int bad;
        bad = 0;
        apply_reset(4'b0100);
        step();
        for (int i = 0; i < 100; i++) begin
            checks++;
            if (select !== 4'b0100 || timeout !== 1'b0) begin
                errors++;
                bad++;
                if (bad < 4)
                    $display("FAIL single_hold cycle=%0d select=%b timeout=%b required 0100/0", i, select, timeout);
            end
            step();
        end
    endtask

    task automatic test_req_drop();
        apply_reset(4'b1111);
        step();
        release_and_expect("drop_setup", 4'b0010);
        // Owner 1 drops; requester 0 also waits, so ptr must be 2 to pick 3.
        req = 4'b1001;
        step();
        checks++;
        if (select !== 4'b0000 || timeout !== 1'b0) begin
            errors++;
            $display("FAIL drop_gap select=%b timeout=%b required 0000/0", select, timeout);
        end
        step();
        checks++;
        if (select !== 4'b1000) begin
            errors++;
            $display("FAIL drop_next select=%b required=1000", select);
        end
    endtask

    task automatic test_async_reset();
        apply_reset(4'b1111);
        step();
        release_and_expect("ar_a", 4'b0010);
        release_and_expect("ar_b", 4'b0100);
        release_and_expect("ar_c", 4'b1000);
        #3;
        rst_n = 1'b0;
        #1;
        checks++;
        if (select !== 4'b0000 || grant_valid !== 1'b0) begin
            errors++;
            $display("FAIL async_reset_drop select=%b gv=%b required 0000/0", select, grant_valid);
        end
        req = 4'b1001;
        step();
        step();
        rst_n = 1'b1;
        step();
        checks++;
        if (select !== 4'b0001) begin
            errors++;
            $display("FAIL async_reset_ptr select=%b required=0001", select);
        end
    endtask

    task automatic test_done_idle_ignored();
        apply_reset(4'b0000);
        done = 1'b1;
        step();
        step();
        done = 1'b0;
        checks++;
        if (select !== 4'b0000 || timeout !== 1'b0) begin
            errors++;
            $display("FAIL idle_done select=%b timeout=%b required 0000/0", select, timeout);
        end
        req = 4'b0010;
        step();
        checks++;
        if (select !== 4'b0010) begin
            errors++;
            $display("FAIL idle_to_grant select=%b required=0010", select);
        end
    endtask

    initial begin
        checks = 0;
        errors = 0;
        rst_n  = 1'b0;
        req    = 4'b0000;
        done   = 1'b0;
        test_reset();
        test_round_robin();
        test_timeout();
        test_done_with_timeout();
        test_single_requester();
        test_req_drop();
        test_async_reset();
        test_done_idle_ignored();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule

`default_nettype wire
